// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Brief    : Shared widths, queue state encoding and saturation limits.
// Revision : 1.0
// ============================================================================
package fir_pkg;

    localparam int IW_DEF = 18;
    localparam int OW_DEF = 12;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } q_state_t;

    function automatic int SAT_MAX(input int ow);
        return (1 << (ow - 1)) - 1;
    endfunction

    function automatic int SAT_MIN(input int ow);
        return -(1 << (ow - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_sat_shift.sv
`default_nettype none
// ============================================================================
// Module   : fir_sat_shift
// Brief    : Arithmetic right shift then saturate a signed IW value to OW bits.
// Revision : 1.0
// ============================================================================
module fir_sat_shift
    import fir_pkg::*;
#(
    parameter int IW    = IW_DEF,
    parameter int OW    = OW_DEF,
    parameter int SHIFT = 4
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout
);

    localparam logic signed [IW-1:0] c_sat_max = IW'(SAT_MAX(OW));
    localparam logic signed [IW-1:0] c_sat_min = IW'(SAT_MIN(OW));

    logic signed [IW-1:0] w_shifted;

    // >>> on a signed operand floors toward -inf
    assign w_shifted = din >>> SHIFT;

    always_comb begin
        dout = w_shifted[OW-1:0];
        if (w_shifted > c_sat_max) begin
            dout = c_sat_max[OW-1:0];
        end else if (w_shifted < c_sat_min) begin
            dout = c_sat_min[OW-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_output_capture.sv
`default_nettype none
// ============================================================================
// Module   : fir_output_capture
// Brief    : Captures scaled FIR results into a 2-deep queue with valid/ready
//            output and sticky overrun / saturating drop counter.
// Revision : 1.0
// ============================================================================
module fir_output_capture
    import fir_pkg::*;
#(
    parameter int IW    = IW_DEF,
    parameter int OW    = OW_DEF,
    parameter int SHIFT = 4,
    parameter int CW    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 count_reach,
    input  logic signed [IW-1:0] din,
    input  logic                 dout_ready,
    output logic signed [OW-1:0] dout,
    output logic                 dout_valid,
    output logic                 overrun,
    output logic [CW-1:0]        drop_count,
    input  logic                 clr_overrun
);

    q_state_t             r_state;
    logic signed [OW-1:0] r_q0;
    logic signed [OW-1:0] r_q1;
    logic                 r_valid;
    logic                 r_overrun;
    logic [CW-1:0]        r_drop_count;

    logic signed [OW-1:0] w_scaled;
    logic                 w_pop;
    logic                 w_drop;

    fir_sat_shift #(
        .IW    (IW),
        .OW    (OW),
        .SHIFT (SHIFT)
    ) u_sat_shift (
        .din  (din),
        .dout (w_scaled)
    );

    assign w_pop  = r_valid & dout_ready;
    // A pop in FULL always makes room, so only an unpopped FULL cycle drops
    assign w_drop = (r_state == FULL) & count_reach & ~w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= EMPTY;
            r_q0         <= '0;
            r_q1         <= '0;
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
            r_drop_count <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (count_reach) begin
                        r_q0    <= w_scaled;
                        r_state <= ONE;
                        r_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (count_reach && !w_pop) begin
                        r_q1    <= w_scaled;
                        r_state <= FULL;
                    end else if (w_pop && !count_reach) begin
                        r_q0    <= '0;
                        r_state <= EMPTY;
                        r_valid <= 1'b0;
                    end else if (count_reach) begin
                        r_q0 <= w_scaled;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_q0 <= r_q1;
                        if (count_reach) begin
                            r_q1 <= w_scaled;
                        end else begin
                            r_state <= ONE;
                        end
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_valid <= 1'b0;
                end
            endcase

            // A drop coinciding with a clear restarts the count at one
            if (w_drop) begin
                r_overrun <= 1'b1;
                if (clr_overrun) begin
                    r_drop_count <= CW'(1);
                end else if (r_drop_count != {CW{1'b1}}) begin
                    r_drop_count <= r_drop_count + CW'(1);
                end
            end else if (clr_overrun) begin
                r_overrun    <= 1'b0;
                r_drop_count <= '0;
            end
        end
    end

    assign dout       = r_q0;
    assign dout_valid = r_valid;
    assign overrun    = r_overrun;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire
